// File: rtl/mips_mem_arbiter.sv
// Arbitrates the MIPS core's instruction and data channels onto one single-port SRAM.
// One transaction in flight at a time; data requests win over instruction fetches.
//
// state | meaning
// IDLE  | accepting requests (acks are combinational here only)
// WR    | SRAM write strobe cycle
// RD    | SRAM read strobe cycle
// WAIT  | counting down SRAM read latency
// IRESP | Instruction held valid until Inst_Ack
// DRESP | Read_data held valid until Read_data_Ack
module mips_mem_arbiter #(
  parameter int ADDR_WIDTH = 10,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           PC,
  input  logic                  Inst_Req_Valid,
  output logic                  Inst_Req_Ack,
  output logic [31:0]           Instruction,
  output logic                  Inst_Valid,
  input  logic                  Inst_Ack,
  input  logic [31:0]           Address,
  input  logic                  MemWrite,
  input  logic [31:0]           Write_data,
  input  logic [3:0]            Write_strb,
  input  logic                  MemRead,
  output logic                  Mem_Req_Ack,
  output logic [31:0]           Read_data,
  output logic                  Read_data_Valid,
  input  logic                  Read_data_Ack,
  output logic                  mem_en,
  output logic [3:0]            mem_wen,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  typedef enum logic [2:0] {IDLE, WR, RD, WAIT, IRESP, DRESP} state_t;

  localparam logic [2:0] LAT_LOAD = 3'(RD_LATENCY - 1);

  state_t     state;
  logic [2:0] lat_cnt;
  logic       src_inst;

  logic idle, take_wr, take_rd, take_inst;

  // Gated by rst so the acks also read 0 while reset is held.
  assign idle      = (state == IDLE) && rst;
  assign take_wr   = idle && MemWrite;
  assign take_rd   = idle && !MemWrite && MemRead;
  assign take_inst = idle && !MemWrite && !MemRead && Inst_Req_Valid;

  assign Mem_Req_Ack  = take_wr || take_rd;
  assign Inst_Req_Ack = take_inst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      lat_cnt         <= '0;
      src_inst        <= 1'b0;
      mem_en          <= 1'b0;
      mem_wen         <= '0;
      mem_addr        <= '0;
      mem_wdata       <= '0;
      Instruction     <= '0;
      Inst_Valid      <= 1'b0;
      Read_data       <= '0;
      Read_data_Valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (take_wr) begin
            state     <= WR;
            mem_en    <= 1'b1;
            mem_wen   <= Write_strb;
            mem_addr  <= Address[ADDR_WIDTH+1:2];
            mem_wdata <= Write_data;
          end else if (take_rd) begin
            state    <= RD;
            mem_en   <= 1'b1;
            mem_wen  <= '0;
            mem_addr <= Address[ADDR_WIDTH+1:2];
            src_inst <= 1'b0;
          end else if (take_inst) begin
            state    <= RD;
            mem_en   <= 1'b1;
            mem_wen  <= '0;
            mem_addr <= PC[ADDR_WIDTH+1:2];
            src_inst <= 1'b1;
          end
        end
        WR: begin
          mem_en  <= 1'b0;
          mem_wen <= '0;
          state   <= IDLE;
        end
        RD: begin
          mem_en  <= 1'b0;
          lat_cnt <= LAT_LOAD;
          state   <= WAIT;
        end
        WAIT: begin
          if (lat_cnt == 3'd0) begin
            if (src_inst) begin
              Instruction <= mem_rdata;
              Inst_Valid  <= 1'b1;
              state       <= IRESP;
            end else begin
              Read_data       <= mem_rdata;
              Read_data_Valid <= 1'b1;
              state           <= DRESP;
            end
          end else begin
            lat_cnt <= lat_cnt - 3'd1;
          end
        end
        IRESP: begin
          if (Inst_Ack) begin
            Inst_Valid <= 1'b0;
            state      <= IDLE;
          end
        end
        DRESP: begin
          if (Read_data_Ack) begin
            Read_data_Valid <= 1'b0;
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
